wam_tap_dbc: RTL
================

// Module: wam_tap_dbc
// PURPOSE
//  Debounced tap detector for the 8 mole switches; sits directly upstream of wam_hit.
//  Synchronises the raw switches and samples them on a slow tick. Each switch toggle
//  that holds for STABLE consecutive ticks becomes exactly one 1-clk tap pulse.
//  Both edges count: a player hits a hole by flipping its switch either way.
// PARAMETERS
//  N        8          number of switch channels
//  SMP_DIV  5_000_000  clk cycles per sample tick (20 Hz at 100 MHz); >=2
//  STABLE   2          consecutive differing ticks needed to accept a toggle; 1..15
// PORTS
//  clk      in   1   system clock
//  clr      in   1   asynchronous active-low reset
//  en       in   1   1 = game running, taps may be emitted; 0 = track level only
//  sw       in   N   raw asynchronous switch inputs
//  tap      out  N   1-clk pulse per accepted toggle, active high (to wam_hit)
//  tap_any  out  1   OR of tap, same cycle
//  lvl      out  N   current debounced switch level
//  tick     out  1   1-clk sample strobe (shared with other timers)
// BEHAVIOUR
//  Reset (clr=0, async): tap=0, tap_any=0, lvl=0, tick=0, divider=0, all channel
//   counters=0, sync flops=0, FSM=INIT.
//  Sync: sw passes through 2 flops (s1->s2). Only s2 is used downstream.
//  Divider: counts 0..SMP_DIV-1 and wraps. tick=1 for exactly the one clk where
//   count==SMP_DIV-1 (registered). First tick comes SMP_DIV clks after clr release.
//  FSM, 2 states:
//   INIT: on the first tick, lvl<=s2 for all bits, no tap, go to RUN. This prevents
//    spurious taps from switches left up at power-on.
//   RUN: per channel i, evaluated only on tick:
//    s2[i]==lvl[i]: cnt[i]<=0.
//    s2[i]!=lvl[i] and cnt[i]+1<STABLE: cnt[i]<=cnt[i]+1.
//    s2[i]!=lvl[i] and cnt[i]+1==STABLE: lvl[i]<=s2[i], cnt[i]<=0, tap[i]<=en.
//   Off-tick clocks: cnt and lvl hold, tap=0.
//  tap: registered, asserted the clk after the qualifying tick, high for 1 clk only.
//   Never high on two consecutive clks.
//  Latency: a clean toggle is seen at tap 2 sync clks + (STABLE-1)..STABLE ticks + 1 clk.
//  Glitch shorter than STABLE ticks: counter returns to 0; no tap; lvl unchanged.
//  Multiple channels toggling in the same tick each pulse in the same clk; tap_any=1.
//  en=0: lvl and cnt still update; the tap for that toggle is lost, not deferred.
//   en changes take effect on the next tick evaluation.
//  clr mid-operation: all state clears at once. FSM re-enters INIT, so no tap is
//   produced for switches that are up when reset releases.
//  Counter width: ceil(log2(SMP_DIV)) for the divider, 4 bits per channel cnt. No
//   arithmetic overflow is possible within the parameter ranges.
// TESTING (SMP_DIV=4, STABLE=2, en=1 unless noted)
//  1 Reset with sw=8'h05, release clr -> lvl=8'h05 after the first tick; tap stays 0
//    for 20 ticks.
//  2 From sw=0, set sw[3]=1 and hold -> exactly one tap=8'h08 pulse, 1 clk wide,
//    on the clk after the 2nd tick that sees s2[3]=1; lvl=8'h08; tap_any=1 that clk.
//  3 sw[3]=1 for 1 tick then back to 0 (bounce) -> no tap; lvl[3] stays 0.
//  4 Set sw[0] and sw[7] together -> tap=8'h81 in one clk; then clear both ->
//    tap=8'h81 again (falling edges count).
//  5 en=0, toggle sw[2] -> lvl[2] follows, tap=0. Set en=1 with no toggle -> still
//    no tap.
//  6 Assert clr midway through a pending toggle (cnt=1), then release -> no tap;
//    INIT reloads lvl from sw.

Source files
------------

// File: rtl/wam_tap_dbc.sv
// rtl/wam_tap_dbc.sv - debounced tap detector for the mole switches
// Synchronises raw switches, samples them on a slow tick, and emits one pulse per accepted toggle.
module wam_tap_dbc #(
  parameter int N       = 8,
  parameter int SMP_DIV = 5_000_000,
  parameter int STABLE  = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] sw,
  output logic [N-1:0] tap,
  output logic         tap_any,
  output logic [N-1:0] lvl,
  output logic         tick
);

  localparam int            DW       = $clog2(SMP_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SMP_DIV - 1);
  localparam logic [3:0]    STB      = 4'(STABLE);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [DW-1:0] div;
  logic [0:0]    state;
  logic [3:0]    cnt [N];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // tick is registered, so it is high while div has just wrapped to 0
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_LAST);
      div  <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

  // INIT adopts the current switch levels so switches left up at power-on never tap
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_INIT;
      lvl   <= '0;
      tap   <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      tap <= '0;
      if (tick) begin
        if (state == S_INIT) begin
          lvl   <= s2;
          state <= S_RUN;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (s2[i] == lvl[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] + 4'd1 < STB) begin
              cnt[i] <= cnt[i] + 4'd1;
            end else begin
              lvl[i] <= s2[i];
              cnt[i] <= '0;
              tap[i] <= en;
            end
          end
        end
      end
    end
  end

  assign tap_any = |tap;

endmodule
